// File: rtl/pipe_hazard_unit_pkg.sv
// pipe_hazard_unit_pkg: shared state and forwarding-select codes for the hazard unit
package pipe_hazard_unit_pkg;
  typedef enum logic {HZ_RUN = 1'b0, HZ_WAIT = 1'b1} hz_state_e;
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;
endpackage

// File: rtl/pipe_hazard_unit_fwd.sv
// pipe_hazard_unit_fwd: EX-stage operand forwarding select for one source register
module pipe_hazard_unit_fwd
  import pipe_hazard_unit_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_wr,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_wr,
  output fwd_sel_t        sel
);
  logic mem_hit, wb_hit;
  always_comb begin
    mem_hit = mem_reg_wr && mem_rd != '0 && mem_rd == rs;
    wb_hit  = wb_reg_wr && wb_rd != '0 && wb_rd == rs;
    sel     = !FWD_EN ? FWD_RF : mem_hit ? FWD_EXMEM : wb_hit ? FWD_MEMWB : FWD_RF;
  end
endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: stall/flush control, operand forwarding and data-memory wait FSM
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int RA_W    = 5,
  parameter int MEM_LAT = 0,
  parameter bit FWD_EN  = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  ex_rs1,
  input  logic [RA_W-1:0]  ex_rs2,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_reg_wr,
  input  logic             ex_mem_rd,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_reg_wr,
  input  logic             mem_access,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             wb_reg_wr,
  input  logic             redirect,
  output logic             pc_wr_en,
  output logic             if_id_wr_en,
  output logic             id_ex_wr_en,
  output logic             ex_mem_wr_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output fwd_sel_t         fwd_a_sel,
  output fwd_sel_t         fwd_b_sel,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WC_W = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  localparam logic [WC_W-1:0] LAT_M1 = WC_W'(MEM_LAT > 0 ? MEM_LAT - 1 : 0);

  hz_state_e state, state_nx;
  logic [WC_W-1:0] wait_cnt, wait_nx;
  logic mem_stall, redir, hazard, data_stall;
  fwd_sel_t fa, fb;

  function automatic logic reads(input logic [RA_W-1:0] rd, input logic [RA_W-1:0] r1,
                                 input logic [RA_W-1:0] r2, input logic u1, input logic u2);
    return rd != '0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
  endfunction

  // Every hazard term is gated by rst_n so outputs sit at their run defaults during reset.
  always_comb begin
    mem_stall  = rst_n && ((state == HZ_RUN && mem_access && MEM_LAT > 0) ||
                           (state == HZ_WAIT && wait_cnt != '0));
    redir      = rst_n && redirect && !mem_stall;
    hazard     = ex_reg_wr && (FWD_EN ? ex_mem_rd : 1'b1) &&
                 reads(ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);
    hazard     = FWD_EN ? hazard : hazard ||
                 (mem_reg_wr && reads(mem_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2)) ||
                 (wb_reg_wr && reads(wb_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2));
    data_stall = rst_n && hazard && !mem_stall && !redir;
    pc_wr_en     = !(mem_stall || data_stall);
    if_id_wr_en  = !(mem_stall || data_stall);
    id_ex_wr_en  = !mem_stall;
    ex_mem_wr_en = !mem_stall;
    if_id_flush  = redir;
    id_ex_flush  = redir || data_stall;
    ex_mem_flush = redir;
    mem_wb_flush = mem_stall;
    mem_busy     = rst_n && state == HZ_WAIT;
    fwd_a_sel    = rst_n ? fa : FWD_RF;
    fwd_b_sel    = rst_n ? fb : FWD_RF;
    state_nx     = mem_stall ? HZ_WAIT : HZ_RUN;
    wait_nx      = !mem_stall ? '0 : state == HZ_RUN ? LAT_M1 : wait_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HZ_RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if ((mem_stall || data_stall) && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (redir && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  pipe_hazard_unit_fwd #(.RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_a (
    .rs(ex_rs1), .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr), .sel(fa)
  );
  pipe_hazard_unit_fwd #(.RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_b (
    .rs(ex_rs2), .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr), .sel(fb)
  );
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: scoreboard bench; dut a has MEM_LAT=3 with forwarding, dut b MEM_LAT=2 without
module tb_pipe_hazard_unit;
  localparam int RA_W = 5;
  localparam int CNT_W = 16;
  localparam logic [12:0] RUNV = 13'b1111_0000_00_00_0;
  localparam logic [12:0] LU   = 13'b0011_0100_00_00_0;
  localparam logic [12:0] MS0  = 13'b0000_0001_00_00_0;
  localparam logic [12:0] MS1  = 13'b0000_0001_00_00_1;
  localparam logic [12:0] REL  = 13'b1111_0000_00_00_1;
  localparam logic [12:0] RD   = 13'b1111_1110_00_00_0;
  localparam logic [12:0] RDR  = 13'b1111_1110_00_00_1;

  logic clk = 1'b0;
  logic rst_n;
  logic [RA_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_reg_wr, ex_mem_rd, mem_reg_wr, mem_access, wb_reg_wr, redirect;
  logic a_pc, a_ifid, a_idex, a_exmem, a_fifid, a_fidex, a_fexmem, a_fmemwb, a_busy;
  logic b_pc, b_ifid, b_idex, b_exmem, b_fifid, b_fidex, b_fexmem, b_fmemwb, b_busy;
  logic [1:0] a_fa, a_fb, b_fa, b_fb;
  logic [CNT_W-1:0] a_stall, a_flush, b_stall, b_flush;
  logic [12:0] oa, ob, o;

  typedef struct {string name; logic d; logic [12:0] v;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [12:0] obs_q[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign oa = {a_pc, a_ifid, a_idex, a_exmem, a_fifid, a_fidex, a_fexmem, a_fmemwb, a_fa, a_fb, a_busy};
  assign ob = {b_pc, b_ifid, b_idex, b_exmem, b_fifid, b_fidex, b_fexmem, b_fmemwb, b_fa, b_fb, b_busy};

  pipe_hazard_unit #(.RA_W(RA_W), .MEM_LAT(3), .FWD_EN(1'b1), .CNT_W(CNT_W)) u_a (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
    .ex_mem_rd(ex_mem_rd), .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .mem_access(mem_access),
    .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr), .redirect(redirect), .pc_wr_en(a_pc), .if_id_wr_en(a_ifid),
    .id_ex_wr_en(a_idex), .ex_mem_wr_en(a_exmem), .if_id_flush(a_fifid), .id_ex_flush(a_fidex),
    .ex_mem_flush(a_fexmem), .mem_wb_flush(a_fmemwb), .fwd_a_sel(a_fa), .fwd_b_sel(a_fb),
    .mem_busy(a_busy), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipe_hazard_unit #(.RA_W(RA_W), .MEM_LAT(2), .FWD_EN(1'b0), .CNT_W(CNT_W)) u_b (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
    .ex_mem_rd(ex_mem_rd), .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .mem_access(mem_access),
    .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr), .redirect(redirect), .pc_wr_en(b_pc), .if_id_wr_en(b_ifid),
    .id_ex_wr_en(b_idex), .ex_mem_wr_en(b_exmem), .if_id_flush(b_fifid), .id_ex_flush(b_fidex),
    .ex_mem_flush(b_fexmem), .mem_wb_flush(b_fmemwb), .fwd_a_sel(b_fa), .fwd_b_sel(b_fb),
    .mem_busy(b_busy), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  task clear_in;
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_reg_wr, ex_mem_rd, mem_reg_wr, mem_access, wb_reg_wr, redirect} = '0;
  endtask

  task tick(input string nm, input logic d, input logic [12:0] v);
    exp_q.push_back('{nm, d, v});
    @(negedge clk);
    obs_q.push_back(d ? ob : oa);
    @(posedge clk);
    #1;
  endtask

  task pulse_reset;
    rst_n = 1'b0;
    clear_in();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task test_reset;
    rst_n = 1'b0;
    clear_in();
    mem_access = 1; redirect = 1; ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 5;
    id_use_rs1 = 1; id_rs1 = 5; mem_rd = 5; mem_reg_wr = 1; ex_rs1 = 5; ex_rs2 = 5;
    tick("reset_a", 0, RUNV);
    tick("reset_b", 1, RUNV);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.name, o, e.v); end
    end
    n_chk++; if (a_stall !== '0) begin n_fail++; $display("FAIL reset_a_stall: got %0d expected 0", a_stall); end
    n_chk++; if (a_flush !== '0) begin n_fail++; $display("FAIL reset_a_flush: got %0d expected 0", a_flush); end
    n_chk++; if (b_stall !== '0) begin n_fail++; $display("FAIL reset_b_stall: got %0d expected 0", b_stall); end
    n_chk++; if (b_flush !== '0) begin n_fail++; $display("FAIL reset_b_flush: got %0d expected 0", b_flush); end
  endtask

  task test_load_use;
    pulse_reset();
    ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5; id_use_rs2 = 1; id_rs2 = 1;
    tick("lu_stall", 0, LU);
    clear_in(); id_use_rs1 = 1; id_rs1 = 5; mem_rd = 5; mem_reg_wr = 1;
    tick("lu_bubble", 0, RUNV);
    clear_in(); ex_rs1 = 5; ex_rs2 = 1; wb_rd = 5; wb_reg_wr = 1;
    tick("lu_fwd_wb", 0, 13'b1111_0000_01_00_0);
    clear_in(); ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 7; id_rs2 = 7; id_use_rs1 = 1; id_rs1 = 3;
    tick("lu_unused_rs2", 0, RUNV);
    clear_in(); ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 0; id_use_rs1 = 1; id_rs1 = 0;
    tick("lu_x0", 0, RUNV);
    clear_in(); ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 7; id_use_rs2 = 1; id_rs2 = 7;
    tick("lu_rs2", 0, LU);
    ex_mem_rd = 0;
    tick("lu_alu_writer", 0, RUNV);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.name, o, e.v); end
    end
    n_chk++; if (a_stall !== 16'd2) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d expected 2", a_stall); end
  endtask

  task test_forward;
    pulse_reset();
    ex_rs1 = 5; ex_rs2 = 5; mem_rd = 5; mem_reg_wr = 1; wb_rd = 5; wb_reg_wr = 1;
    tick("fwd_mem_wins", 0, 13'b1111_0000_10_10_0);
    clear_in(); ex_rs2 = 7; mem_reg_wr = 1; wb_rd = 7; wb_reg_wr = 1;
    tick("fwd_x0_mem", 0, 13'b1111_0000_00_01_0);
    clear_in(); ex_rs1 = 5; mem_rd = 5; ex_rs2 = 9; wb_rd = 9; wb_reg_wr = 1;
    tick("fwd_mem_no_wr", 0, 13'b1111_0000_00_01_0);
    clear_in(); mem_reg_wr = 1; wb_reg_wr = 1;
    tick("fwd_x0_all", 0, RUNV);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.name, o, e.v); end
    end
  endtask

  task test_back_to_back;
    pulse_reset();
    mem_access = 1;
    for (int k = 0; k < 2; k++) begin
      tick("mw_first", 0, MS0);
      tick("mw_wait", 0, MS1);
      tick("mw_wait_last", 0, MS1);
      tick("mw_release", 0, REL);
    end
    mem_access = 0;
    tick("mw_idle", 0, RUNV);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.name, o, e.v); end
    end
    n_chk++; if (a_stall !== 16'd6) begin n_fail++; $display("FAIL mw_stall_cnt: got %0d expected 6", a_stall); end
  endtask

  task test_redirect;
    pulse_reset();
    redirect = 1;
    tick("redir", 0, RD);
    ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5;
    tick("redir_over_lu", 0, RD);
    clear_in();
    tick("redir_idle", 0, RUNV);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.name, o, e.v); end
    end
    n_chk++; if (a_flush !== 16'd2) begin n_fail++; $display("FAIL redir_flush_cnt: got %0d expected 2", a_flush); end
    n_chk++; if (a_stall !== 16'd0) begin n_fail++; $display("FAIL redir_stall_cnt: got %0d expected 0", a_stall); end
  endtask

  task test_fwd_off;
    pulse_reset();
    wb_rd = 5; wb_reg_wr = 1; id_use_rs1 = 1; id_rs1 = 5; ex_rs1 = 5;
    tick("raw_wb", 1, LU);
    clear_in(); ex_reg_wr = 1; ex_rd = 3; id_use_rs2 = 1; id_rs2 = 3; mem_rd = 3; mem_reg_wr = 1; ex_rs2 = 3;
    tick("raw_ex_alu", 1, LU);
    clear_in(); id_use_rs1 = 1; id_rs1 = 6; wb_rd = 5; wb_reg_wr = 1; ex_rs1 = 5;
    tick("raw_none", 1, RUNV);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.name, o, e.v); end
    end
    n_chk++; if (b_stall !== 16'd2) begin n_fail++; $display("FAIL raw_stall_cnt: got %0d expected 2", b_stall); end
  endtask

  task test_mem_redirect;
    pulse_reset();
    mem_access = 1; redirect = 1;
    tick("mr_stall0", 1, MS0);
    tick("mr_stall1", 1, MS1);
    tick("mr_release_redir", 1, RDR);
    clear_in();
    tick("mr_idle", 1, RUNV);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.name, o, e.v); end
    end
    n_chk++; if (b_stall !== 16'd2) begin n_fail++; $display("FAIL mr_stall_cnt: got %0d expected 2", b_stall); end
    n_chk++; if (b_flush !== 16'd1) begin n_fail++; $display("FAIL mr_flush_cnt: got %0d expected 1", b_flush); end
    mem_access = 1;
    tick("rw_enter", 1, MS0);
    clear_in();
    rst_n = 1'b0;
    tick("rw_in_reset", 1, RUNV);
    n_chk++; if (b_stall !== '0) begin n_fail++; $display("FAIL rw_stall_cnt: got %0d expected 0", b_stall); end
    n_chk++; if (b_flush !== '0) begin n_fail++; $display("FAIL rw_flush_cnt: got %0d expected 0", b_flush); end
    rst_n = 1'b1;
    tick("rw_after_reset", 1, RUNV);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.name, o, e.v); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_back_to_back();
    test_redirect();
    test_fwd_off();
    test_mem_redirect();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
